// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared idle levels and default debounce length for the board input front end.
package input_conditioner_pkg;
    localparam int   DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam logic BUTTON_IDLE             = 1'b1;
    localparam logic SWITCH_IDLE             = 1'b0;
endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// input_conditioner_debounce_channel: synchronises one raw input and accepts a new level only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the current stable level.
module input_conditioner_debounce_channel #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic IDLE            = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Any return to the stable level clears the count, so only an unbroken run can reach terminal.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{IDLE}};
            stable <= IDLE;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == TERMINAL) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces the two active-low buttons and two level switches, then derives
// the fertilise strobe, reset pulse and registered switch decode for the irrigation FSMs.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic fertilise_button,
    input  logic reset_button,
    input  logic splinker_switch,
    input  logic dripper_switch,
    output logic fertilise_push,
    output logic reset_pulse,
    output logic splinker_level,
    output logic dripper_level,
    output logic irrigation_allowed,
    output logic input_error
);
    logic fert_stable;
    logic rst_stable;
    logic fert_d;

    input_conditioner_debounce_channel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(BUTTON_IDLE)
    ) u_fert (.clock(clock), .reset(reset), .raw(fertilise_button), .stable(fert_stable));

    input_conditioner_debounce_channel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(BUTTON_IDLE)
    ) u_rst (.clock(clock), .reset(reset), .raw(reset_button), .stable(rst_stable));

    input_conditioner_debounce_channel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(SWITCH_IDLE)
    ) u_splinker (.clock(clock), .reset(reset), .raw(splinker_switch), .stable(splinker_level));

    input_conditioner_debounce_channel #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(SWITCH_IDLE)
    ) u_dripper (.clock(clock), .reset(reset), .raw(dripper_switch), .stable(dripper_level));

    // Strobe fires on the press edge only (stable 1->0); the delayed copy starts released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fert_d             <= BUTTON_IDLE;
            fertilise_push     <= 1'b0;
            reset_pulse        <= 1'b0;
            irrigation_allowed <= 1'b0;
            input_error        <= 1'b0;
        end else begin
            fert_d             <= fert_stable;
            fertilise_push     <= fert_d & ~fert_stable;
            reset_pulse        <= ~rst_stable;
            irrigation_allowed <= splinker_level ^ dripper_level;
            input_error        <= splinker_level & dripper_level;
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table-driven stimulus with a per-cycle expected-output scoreboard queue.
module tb_input_conditioner;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic fert = 1'b1, rstb = 1'b1, spl = 1'b0, drp = 1'b0;
    logic fertilise_push, reset_pulse, splinker_level, dripper_level, irrigation_allowed, input_error;
    logic [5:0] dut_vec;

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    typedef struct {
        logic [3:0] in;
        int         n;
        logic [5:0] v0;
        int         t1;
        logic [5:0] v1;
        int         t2;
        logic [5:0] v2;
        int         push_at;
    } vec_t;

    vec_t tbl[19];

    input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .fertilise_button(fert), .reset_button(rstb),
        .splinker_switch(spl), .dripper_switch(drp),
        .fertilise_push(fertilise_push), .reset_pulse(reset_pulse),
        .splinker_level(splinker_level), .dripper_level(dripper_level),
        .irrigation_allowed(irrigation_allowed), .input_error(input_error)
    );

    assign dut_vec = {fertilise_push, reset_pulse, splinker_level, dripper_level, irrigation_allowed, input_error};

    always #5 clock = ~clock;

    // Drive {fert,rstb,spl,drp} for n cycles; sample i (after rising edge i) expects
    // v0 before t1, v1 before t2, v2 after, plus the push bit at push_at.
    task automatic run(input logic [3:0] in, input int n, input logic [5:0] v0, input int t1,
                       input logic [5:0] v1, input int t2, input logic [5:0] v2,
                       input int push_at, input int tag);
        logic [5:0] e;
        {fert, rstb, spl, drp} = in;
        for (int i = 1; i <= n; i++)
            exp_q.push_back((i < t1 ? v0 : i < t2 ? v1 : v2) | (i == push_at ? 6'b100000 : 6'b000000));
        for (int i = 1; i <= n; i++) begin
            @(posedge clock);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL step%0d cycle%0d: got %b expected %b ({push,rp,spl,drp,allowed,err})",
                         tag, i, dut_vec, e);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{4'b1100,  8, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[1]  = '{4'b0100, 20, 6'b000000, 0, 6'b000000, 0, 6'b000000, 7};
        tbl[2]  = '{4'b1100, 12, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[3]  = '{4'b0100,  3, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[4]  = '{4'b1100,  1, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[5]  = '{4'b0100,  3, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[6]  = '{4'b1100, 10, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[7]  = '{4'b0100, 20, 6'b000000, 0, 6'b000000, 0, 6'b000000, 7};
        tbl[8]  = '{4'b1100, 12, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[9]  = '{4'b1000, 10, 6'b000000, 7, 6'b010000, 7, 6'b010000, 0};
        tbl[10] = '{4'b1100, 10, 6'b010000, 7, 6'b000000, 7, 6'b000000, 0};
        tbl[11] = '{4'b1110, 10, 6'b000000, 6, 6'b001000, 7, 6'b001010, 0};
        tbl[12] = '{4'b1111, 10, 6'b001010, 6, 6'b001110, 7, 6'b001101, 0};
        tbl[13] = '{4'b0000, 12, 6'b001101, 6, 6'b000001, 7, 6'b010000, 7};
        tbl[14] = '{4'b1100, 12, 6'b010000, 7, 6'b000000, 7, 6'b000000, 0};
        tbl[15] = '{4'b1101,  2, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[16] = '{4'b1100, 10, 6'b000000, 0, 6'b000000, 0, 6'b000000, 0};
        tbl[17] = '{4'b1101, 10, 6'b000000, 6, 6'b000100, 7, 6'b000110, 0};
        tbl[18] = '{4'b1100, 10, 6'b000110, 6, 6'b000010, 7, 6'b000000, 0};

        // Reset held while inputs toggle: everything stays 0.
        @(negedge clock);
        for (int i = 0; i < 10; i++)
            run(4'($urandom), 1, 6'b0, 0, 6'b0, 0, 6'b0, 0, 100 + i);
        {fert, rstb, spl, drp} = 4'b1100;
        reset = 1'b1;

        for (int k = 0; k < 19; k++)
            run(tbl[k].in, tbl[k].n, tbl[k].v0, tbl[k].t1, tbl[k].v1, tbl[k].t2, tbl[k].v2,
                tbl[k].push_at, k);

        // Async reset mid-count discards progress; full debounce needed after release.
        run(4'b0100, 4, 6'b0, 0, 6'b0, 0, 6'b0, 0, 200);
        reset = 1'b0;
        run(4'b0100, 2, 6'b0, 0, 6'b0, 0, 6'b0, 0, 201);
        reset = 1'b1;
        run(4'b0100, 12, 6'b0, 0, 6'b0, 0, 6'b0, 7, 202);
        run(4'b1100, 12, 6'b0, 0, 6'b0, 0, 6'b0, 0, 203);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
